blink_module: RTL

Output-side counterpart to the key debounce path: takes single-cycle event strobes from the core logic and drives an LED/indicator pin with clean, human-visible pulses of guaranteed minimum high and low time. Each accepted strobe produces exactly one blink. Strobes arriving while a blink is in progress are queued and replayed back-to-back. It sits between event sources (debounced key edges, status flags) and board output pins.

---
 rtl/blink_pkg.sv | 26 ++
 rtl/blink_timer_module.sv | 35 +++
 rtl/blink_module.sv | 103 ++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared constants, state encoding and width helper for the blink indicator path.
package blink_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StGap  = 2'd2
  } blink_state_e;

  localparam int unsigned ClkFreqHz    = 50_000_000;
  localparam int unsigned DefOnCycles  = 5_000_000;
  localparam int unsigned DefOffCycles = 5_000_000;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned blink_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/blink_timer_module.sv
// Loadable down-counter shared by the ON and GAP phases; Done flags the last cycle.
module blink_timer_module
  import blink_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Load,
  input  logic [Width-1:0] Load_Val,
  output logic             Done
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = Load_Val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Done = (count_q == Width'(1));

endmodule

// File: rtl/blink_module.sv
// Turns single-cycle event strobes into LED blinks with guaranteed high and low time.
// Define BLINK_QUEUE_EN to queue strobes that arrive mid-blink and replay them back-to-back.
module blink_module
  import blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DefOnCycles,
  parameter int unsigned OFF_CYCLES = DefOffCycles,
  parameter int unsigned PEND_W     = 4
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Trig_Sig,
  output logic Pin_Out,
  output logic Busy
);

  localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TimerW    = blink_clog2(MaxCycles + 1);

  blink_state_e      state_q;
  logic              timer_load;
  logic              timer_done;
  logic [TimerW-1:0] timer_val;
  logic              final_gap;
  logic              start_on;
  logic              start_gap;
  logic              pend_nz;

  // A queued blink or a fresh strobe in the last GAP cycle chains straight into ON.
  always_comb begin
    final_gap  = (state_q == StGap) && timer_done;
    start_on   = ((state_q == StIdle) && Trig_Sig) || (final_gap && (pend_nz || Trig_Sig));
    start_gap  = (state_q == StOn) && timer_done;
    timer_load = start_on || start_gap;
    timer_val  = start_on ? TimerW'(ON_CYCLES) : TimerW'(OFF_CYCLES);
  end

  blink_timer_module #(
    .Width(TimerW)
  ) u_timer (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .Load    (timer_load),
    .Load_Val(timer_val),
    .Done    (timer_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= StIdle;
      Pin_Out <= 1'b0;
      Busy    <= 1'b0;
    end else if (start_on) begin
      state_q <= StOn;
      Pin_Out <= 1'b1;
      Busy    <= 1'b1;
    end else if (start_gap) begin
      state_q <= StGap;
      Pin_Out <= 1'b0;
      Busy    <= 1'b1;
    end else if (final_gap) begin
      state_q <= StIdle;
      Pin_Out <= 1'b0;
      Busy    <= 1'b0;
    end
  end

`ifdef BLINK_QUEUE_EN
  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_inc;
  logic              pend_dec;

  // In the last GAP cycle with nothing queued the strobe is consumed directly, not counted.
  always_comb begin
    pend_inc = Trig_Sig && (state_q != StIdle) && (pend_q != PendMax) &&
               !(final_gap && !pend_nz);
    pend_dec = final_gap && pend_nz;
    pend_d   = pend_q;
    if (pend_inc && !pend_dec) begin
      pend_d = pend_q + PendOne;
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PendOne;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_nz = |pend_q;
`else
  // No queue: PEND_W has no effect on behaviour.
  assign pend_nz = (PEND_W == 0) ? 1'b0 : 1'b0;
`endif

endmodule
